time_adjust_ctrl: RTL and testbench

Key-driven calibration controller that writes the time counter's adjust interface. Debounced single-cycle key pulses select the display/calibration mode and toggle between time and date. In calibration mode they also pick a two-digit BCD field and step it up or down with legal-range wrap. The block drives `model`, `date_time_ch`, `adjust_time_num` and `adjust_date_num` into the time counter, and `field_sel`/`blink` into the display driver.

---
 rtl/time_adjust_ctrl.sv | 179 +++++++++++++++++
 tb/tb_time_adjust_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_adjust_ctrl.sv
// Key-driven calibration controller for the time counter's adjust interface.
// It handles mode stepping, time/date toggle, BCD field editing with legal-range wrap, and a field blink.
module time_adjust_ctrl #(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_ch,
  input  logic        key_sel,
  input  logic        key_up,
  input  logic        key_down,
  input  logic [23:0] time_num,
  input  logic [23:0] data_num,
  output logic [1:0]  model,
  output logic        date_time_ch,
  output logic [23:0] adjust_time_num,
  output logic [23:0] adjust_date_num,
  output logic [1:0]  field_sel,
  output logic        blink
);

  localparam int CNT_W = $clog2(BLINK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_TIME = 2'b00,
    MODE_DATE = 2'b01,
    MODE_RSVD = 2'b10,
    MODE_CAL  = 2'b11
  } mode_t;

  mode_t            mode_reg, mode_next;
  logic             dtc_reg, dtc_next;
  logic [23:0]      adj_time_reg, adj_time_next;
  logic [23:0]      adj_date_reg, adj_date_next;
  logic [1:0]       field_sel_reg, field_sel_next;
  logic             blink_reg, blink_next;
  logic [CNT_W-1:0] blink_cnt_reg, blink_cnt_next;

  logic       cal;
  logic       key_taken;
  logic [7:0] fld_val, fld_min, fld_max, fld_new, new_month_days;

  function automatic logic [7:0] days_in_month(input logic [7:0] mon);
    case (mon)
      8'h02:                      return 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  // For valid BCD, comparing the raw byte orders values numerically.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lo_lim,
                                          input logic [7:0] hi_lim, input logic up);
    logic legal;
    legal = (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v >= lo_lim) && (v <= hi_lim);
    if (!legal) return lo_lim;
    if (up) begin
      if (v == hi_lim)       return lo_lim;
      if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
    end
    if (v == lo_lim)         return hi_lim;
    if (v[3:0] == 4'd0)      return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign cal = (mode_reg == MODE_CAL);

  // Select the field being edited and its legal range.
  always_comb begin
    fld_val = 8'h00;
    fld_min = 8'h00;
    fld_max = 8'h59;
    if (!dtc_reg) begin
      case (field_sel_reg)
        2'd2:    begin fld_val = adj_time_reg[23:16]; fld_max = 8'h23; end
        2'd1:    fld_val = adj_time_reg[15:8];
        default: fld_val = adj_time_reg[7:0];
      endcase
    end else begin
      case (field_sel_reg)
        2'd2:    begin fld_val = adj_date_reg[23:16]; fld_max = 8'h99; end
        2'd1:    begin fld_val = adj_date_reg[15:8]; fld_min = 8'h01; fld_max = 8'h12; end
        default: begin
          fld_val = adj_date_reg[7:0];
          fld_min = 8'h01;
          fld_max = days_in_month(adj_date_reg[15:8]);
        end
      endcase
    end
    fld_new        = bcd_step(fld_val, fld_min, fld_max, key_up);
    new_month_days = days_in_month(fld_new);
  end

  always_comb begin
    mode_next      = mode_reg;
    dtc_next       = dtc_reg;
    adj_time_next  = adj_time_reg;
    adj_date_next  = adj_date_reg;
    field_sel_next = field_sel_reg;
    blink_next     = blink_reg;
    blink_cnt_next = blink_cnt_reg;
    key_taken      = 1'b1;

    if (key_mode) begin
      mode_next = mode_t'(mode_reg + 2'd1);
      if (mode_reg == MODE_RSVD) begin
        adj_time_next  = time_num;
        adj_date_next  = data_num;
        field_sel_next = 2'd2;
      end
    end else if (key_ch) begin
      dtc_next = ~dtc_reg;
      if (cal) field_sel_next = 2'd2;
    end else if (cal && key_sel) begin
      field_sel_next = (field_sel_reg == 2'd0) ? 2'd2 : field_sel_reg - 2'd1;
    end else if (cal && (key_up || key_down)) begin
      if (!dtc_reg) begin
        case (field_sel_reg)
          2'd2:    adj_time_next[23:16] = fld_new;
          2'd1:    adj_time_next[15:8]  = fld_new;
          default: adj_time_next[7:0]   = fld_new;
        endcase
      end else begin
        case (field_sel_reg)
          2'd2:    adj_date_next[23:16] = fld_new;
          2'd1: begin
            adj_date_next[15:8] = fld_new;
            if (adj_date_reg[7:0] > new_month_days) adj_date_next[7:0] = new_month_days;
          end
          default: adj_date_next[7:0] = fld_new;
        endcase
      end
    end else begin
      key_taken = 1'b0;
    end

    // Any accepted key restarts the phase so the edited field shows at once.
    if (mode_next != MODE_CAL || key_taken) begin
      blink_next     = 1'b0;
      blink_cnt_next = '0;
    end else if (blink_cnt_reg == CNT_LAST) begin
      blink_next     = ~blink_reg;
      blink_cnt_next = '0;
    end else begin
      blink_cnt_next = blink_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg      <= MODE_TIME;
      dtc_reg       <= 1'b0;
      adj_time_reg  <= 24'h000000;
      adj_date_reg  <= 24'h000101;
      field_sel_reg <= 2'd2;
      blink_reg     <= 1'b0;
      blink_cnt_reg <= '0;
    end else begin
      mode_reg      <= mode_next;
      dtc_reg       <= dtc_next;
      adj_time_reg  <= adj_time_next;
      adj_date_reg  <= adj_date_next;
      field_sel_reg <= field_sel_next;
      blink_reg     <= blink_next;
      blink_cnt_reg <= blink_cnt_next;
    end
  end

  assign model           = mode_reg;
  assign date_time_ch    = dtc_reg;
  assign adjust_time_num = adj_time_reg;
  assign adjust_date_num = adj_date_reg;
  assign field_sel       = field_sel_reg;
  assign blink           = blink_reg;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Self-checking bench for time_adjust_ctrl: directed scenarios plus random keys,
// compared against a behavioural model using integer arithmetic on field values.
module tb_time_adjust_ctrl;

  localparam int DIV = 4;
  localparam logic [4:0] K_M = 5'b10000;
  localparam logic [4:0] K_C = 5'b01000;
  localparam logic [4:0] K_S = 5'b00100;
  localparam logic [4:0] K_U = 5'b00010;
  localparam logic [4:0] K_D = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_mode, key_ch, key_sel, key_up, key_down;
  logic [23:0] time_num, data_num;
  logic [1:0]  model;
  logic        date_time_ch;
  logic [23:0] adjust_time_num, adjust_date_num;
  logic [1:0]  field_sel;
  logic        blink;

  int total = 0;
  int bad   = 0;

  time_adjust_ctrl #(.BLINK_DIV(DIV)) dut (
    .clk(clk), .rst(rst),
    .key_mode(key_mode), .key_ch(key_ch), .key_sel(key_sel),
    .key_up(key_up), .key_down(key_down),
    .time_num(time_num), .data_num(data_num),
    .model(model), .date_time_ch(date_time_ch),
    .adjust_time_num(adjust_time_num), .adjust_date_num(adjust_date_num),
    .field_sel(field_sel), .blink(blink)
  );

  always #5 clk = ~clk;

  // Reference state: fields kept as BCD bytes, index 2 = hh/yy, 0 = ss/dd.
  int         m_mode, m_fsel, m_k;
  bit         m_dtc;
  logic [7:0] m_t[3];
  logic [7:0] m_d[3];
  int         dim_tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic int month_days(input logic [7:0] mon);
    int n = bcd_val(mon);
    if (mon[7:4] > 4'd9 || mon[3:0] > 4'd9 || n < 1 || n > 12) return 31;
    return dim_tab[n-1];
  endfunction

  function automatic logic [7:0] ref_step(input logic [7:0] v, input int lo, input int hi, input bit up);
    int n = bcd_val(v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || n < lo || n > hi) return to_bcd(lo);
    if (up) n = (n == hi) ? lo : n + 1;
    else    n = (n == lo) ? hi : n - 1;
    return to_bcd(n);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_dtc = 0; m_fsel = 2; m_k = 0;
    m_t[2] = 8'h00; m_t[1] = 8'h00; m_t[0] = 8'h00;
    m_d[2] = 8'h00; m_d[1] = 8'h01; m_d[0] = 8'h01;
  endtask

  task automatic model_update(input logic [4:0] k);
    bit accepted = 1;
    int lo, hi;
    if (k[4]) begin
      if (m_mode == 2) begin
        m_t[2] = time_num[23:16]; m_t[1] = time_num[15:8]; m_t[0] = time_num[7:0];
        m_d[2] = data_num[23:16]; m_d[1] = data_num[15:8]; m_d[0] = data_num[7:0];
        m_fsel = 2;
      end
      m_mode = (m_mode + 1) % 4;
    end else if (k[3]) begin
      m_dtc = !m_dtc;
      if (m_mode == 3) m_fsel = 2;
    end else if (m_mode == 3 && k[2]) begin
      m_fsel = (m_fsel + 2) % 3;
    end else if (m_mode == 3 && (k[1] || k[0])) begin
      if (!m_dtc) begin
        hi = (m_fsel == 2) ? 23 : 59;
        m_t[m_fsel] = ref_step(m_t[m_fsel], 0, hi, k[1]);
      end else begin
        case (m_fsel)
          2:       begin lo = 0; hi = 99; end
          1:       begin lo = 1; hi = 12; end
          default: begin lo = 1; hi = month_days(m_d[1]); end
        endcase
        m_d[m_fsel] = ref_step(m_d[m_fsel], lo, hi, k[1]);
        if (m_fsel == 1 && bcd_val(m_d[0]) > month_days(m_d[1]))
          m_d[0] = to_bcd(month_days(m_d[1]));
      end
    end else begin
      accepted = 0;
    end
    if (m_mode != 3 || accepted) m_k = 0;
    else m_k++;
  endtask

  task automatic check_all(input string tag);
    bit exp_blink = (m_mode == 3) && (((m_k / DIV) % 2) == 1);
    chk({tag, ".model"}, 24'(model), 24'(m_mode));
    chk({tag, ".dtc"}, 24'(date_time_ch), 24'(m_dtc));
    chk({tag, ".time"}, adjust_time_num, {m_t[2], m_t[1], m_t[0]});
    chk({tag, ".date"}, adjust_date_num, {m_d[2], m_d[1], m_d[0]});
    chk({tag, ".sel"}, 24'(field_sel), 24'(m_fsel));
    chk({tag, ".blink"}, 24'(blink), 24'(exp_blink));
  endtask

  task automatic do_cycle(input logic [4:0] k);
    {key_mode, key_ch, key_sel, key_up, key_down} = k;
    model_update(k);
    @(posedge clk);
    #1;
    {key_mode, key_ch, key_sel, key_up, key_down} = 5'b0;
    check_all("cyc");
    $display("cyc keys=%b model=%0d dtc=%0d time=%h date=%h sel=%0d blink=%0d",
             k, model, date_time_ch, adjust_time_num, adjust_date_num, field_sel, blink);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    chk("rst_date", adjust_date_num, 24'h000101);
    $display("rst model=%0d time=%h date=%h sel=%0d blink=%0d",
             model, adjust_time_num, adjust_date_num, field_sel, blink);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rnd_bcd();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin
    logic [4:0] k;
    rst = 1'b1;
    {key_mode, key_ch, key_sel, key_up, key_down} = 5'b0;
    time_num = 24'h235659;
    data_num = 24'h200131;
    model_reset();
    #12;
    check_all("reset");
    chk("reset_date", adjust_date_num, 24'h000101);
    rst = 1'b0;

    // Enter calibration with a snapshot on the third mode press
    repeat (3) do_cycle(K_M);
    chk("enter_model", 24'(model), 24'd3);
    chk("snap_time", adjust_time_num, 24'h235659);
    do_cycle(K_U); chk("hour_up_wrap", adjust_time_num, 24'h005659);
    do_cycle(K_D); chk("hour_dn_wrap", adjust_time_num, 24'h235659);
    do_cycle(K_S); do_cycle(K_S);
    chk("sel_sec", 24'(field_sel), 24'd0);
    do_cycle(K_U); chk("sec_up_wrap", adjust_time_num, 24'h235600);
    do_cycle(K_D); chk("sec_dn_wrap", adjust_time_num, 24'h235659);

    // Date editing with month clamp and day wrap
    do_cycle(K_C); chk("ch_sel", 24'(field_sel), 24'd2);
    do_cycle(K_S); chk("sel_month", 24'(field_sel), 24'd1);
    do_cycle(K_U); chk("month_clamp", adjust_date_num, 24'h200228);
    do_cycle(K_S); do_cycle(K_U);
    chk("day_wrap", adjust_date_num, 24'h200201);

    data_num = 24'h991231;
    repeat (4) do_cycle(K_M);
    do_cycle(K_U); chk("year_wrap", adjust_date_num, 24'h001231);
    do_cycle(K_S); do_cycle(K_U);
    chk("month_wrap", adjust_date_num, 24'h000131);

    data_num = 24'h00013A;
    repeat (4) do_cycle(K_M);
    do_cycle(K_S); do_cycle(K_S); do_cycle(K_U);
    chk("illegal_day", adjust_date_num, 24'h000101);

    do_cycle(K_M | K_U);
    chk("prio_model", 24'(model), 24'd0);
    chk("prio_hold", adjust_date_num, 24'h000101);

    // Blink phase and restart on a key
    repeat (3) do_cycle(K_M);
    repeat (3) do_cycle(5'b0);
    chk("blink_low", 24'(blink), 24'd0);
    do_cycle(5'b0); chk("blink_high", 24'(blink), 24'd1);
    repeat (2) do_cycle(5'b0);
    do_cycle(K_U); chk("blink_clear", 24'(blink), 24'd0);
    repeat (3) do_cycle(5'b0);
    chk("blink_restart", 24'(blink), 24'd0);
    do_cycle(5'b0); chk("blink_again", 24'(blink), 24'd1);

    do_cycle(K_U);
    async_reset();

    // Random stimulus
    for (int i = 0; i < 1500; i++) begin
      time_num = ($urandom_range(0, 1) == 0) ? 24'($urandom) : {rnd_bcd(), rnd_bcd(), rnd_bcd()};
      data_num = {($urandom_range(0, 1) == 0) ? 8'($urandom) : rnd_bcd(),
                  ($urandom_range(0, 1) == 0) ? 8'($urandom) : rnd_bcd(),
                  rnd_bcd()};
      k = 5'b0;
      if ($urandom_range(0, 19) == 0) k[4] = 1'b1;
      if ($urandom_range(0, 14) == 0) k[3] = 1'b1;
      if ($urandom_range(0, 5) == 0)  k[2] = 1'b1;
      if ($urandom_range(0, 3) == 0)  k[1] = 1'b1;
      if ($urandom_range(0, 3) == 0)  k[0] = 1'b1;
      do_cycle(k);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
